// File: rtl/multiplier_accumulator_if.sv
// multiplier_accumulator_if: operand/result bus for the shift-add multiply-accumulate unit
interface multiplier_accumulator_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] multiplicand_in;
  logic [WIDTH-1:0] multiplier_in;
  logic [WIDTH-1:0] addend_in;
  logic             data_valid_in;
  logic [WIDTH-1:0] product_out;
  logic [WIDTH-1:0] product_hi_out;
  logic             overflow_out;
  logic             data_valid_out;
  logic             busy_out;
  modport master (
    output multiplicand_in, multiplier_in, addend_in, data_valid_in,
    input  product_out, product_hi_out, overflow_out, data_valid_out, busy_out
  );
  modport slave (
    input  multiplicand_in, multiplier_in, addend_in, data_valid_in,
    output product_out, product_hi_out, overflow_out, data_valid_out, busy_out
  );
endinterface

// File: rtl/multiplier_accumulator.sv
// multiplier_accumulator: iterative radix-2 A*B+C; define MAC_SATURATE_EN to saturate product_out on overflow
module multiplier_accumulator #(parameter int WIDTH = 32) (
  input logic clk_in,
  input logic rst_in,
  multiplier_accumulator_if.slave bus
);
  typedef enum logic {IDLE, MULT} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0] mplier, lo_nx;
  logic accept, done, ovf;
  always_comb begin
    accept = state == IDLE && bus.data_valid_in;
    done = state == MULT && mplier == '0;
    state_nx = accept ? MULT : done ? IDLE : state;
    ovf = |acc[2*WIDTH-1:WIDTH];
`ifdef MAC_SATURATE_EN
    lo_nx = ovf ? '1 : acc[WIDTH-1:0];
`else
    lo_nx = acc[WIDTH-1:0];
`endif
  end
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      bus.product_out <= '0;
      bus.product_hi_out <= '0;
      bus.overflow_out <= 1'b0;
      bus.data_valid_out <= 1'b0;
      bus.busy_out <= 1'b0;
    end else begin
      bus.data_valid_out <= done;
      if (accept) begin
        acc <= {{WIDTH{1'b0}}, bus.addend_in};
        mcand <= {{WIDTH{1'b0}}, bus.multiplicand_in};
        mplier <= bus.multiplier_in;
        bus.busy_out <= 1'b1;
      end else if (done) begin
        bus.product_out <= lo_nx;
        bus.product_hi_out <= acc[2*WIDTH-1:WIDTH];
        bus.overflow_out <= ovf;
        bus.busy_out <= 1'b0;
      end else if (state == MULT) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end
endmodule
